// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between EXU and LSU.
// Combinational valid/ready grant with a single registered writeback stage.
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [RW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_wd,
  input  logic            exu_reg_we,
  input  logic [CW-1:0]   exu_csr_rd,
  input  logic [XLEN-1:0] exu_csr_wd,
  input  logic            exu_csr_we,
  input  logic            exu_ecall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  input  logic            lsu_reg_we,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_wd,
  output logic            wb_reg_we,
  output logic [CW-1:0]   wb_csr_rd,
  output logic [XLEN-1:0] wb_csr_wd,
  output logic            wb_csr_we,
  output logic            wb_ecall,
  output logic            wb_src
);

  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  logic            exu_gnt_s, lsu_gnt_s;
  logic            last_d, last_q;
  logic            valid_d, valid_q;
  logic [RW-1:0]   rd_d, rd_q;
  logic [XLEN-1:0] wd_d, wd_q;
  logic            reg_we_d, reg_we_q;
  logic [CW-1:0]   csr_rd_d, csr_rd_q;
  logic [XLEN-1:0] csr_wd_d, csr_wd_q;
  logic            csr_we_d, csr_we_q;
  logic            ecall_d, ecall_q;
  logic            src_d, src_q;

  // Grant: ties go to whoever was not served last; payload never affects ready.
  always_comb begin
    exu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (hold) begin
      exu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end else if (exu_valid && lsu_valid) begin
      if (last_q == SRC_LSU) begin
        exu_gnt_s = 1'b1;
      end else begin
        lsu_gnt_s = 1'b1;
      end
    end else if (exu_valid) begin
      exu_gnt_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_gnt_s = 1'b1;
    end else begin
      exu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign exu_ready = exu_gnt_s;
  assign lsu_ready = lsu_gnt_s;

  // Next writeback stage: enables drop without a transfer, data fields hold.
  always_comb begin
    last_d   = last_q;
    valid_d  = 1'b0;
    rd_d     = rd_q;
    wd_d     = wd_q;
    reg_we_d = 1'b0;
    csr_rd_d = csr_rd_q;
    csr_wd_d = csr_wd_q;
    csr_we_d = 1'b0;
    ecall_d  = 1'b0;
    src_d    = src_q;
    if (exu_gnt_s) begin
      last_d   = SRC_EXU;
      valid_d  = 1'b1;
      rd_d     = exu_rd;
      wd_d     = exu_wd;
      reg_we_d = exu_reg_we && (exu_rd != {RW{1'b0}});
      csr_rd_d = exu_csr_rd;
      csr_wd_d = exu_csr_wd;
      csr_we_d = exu_csr_we;
      ecall_d  = exu_ecall;
      src_d    = SRC_EXU;
    end else if (lsu_gnt_s) begin
      last_d   = SRC_LSU;
      valid_d  = 1'b1;
      rd_d     = lsu_rd;
      wd_d     = lsu_wd;
      reg_we_d = lsu_reg_we && (lsu_rd != {RW{1'b0}});
      csr_rd_d = {CW{1'b0}};
      csr_wd_d = {XLEN{1'b0}};
      csr_we_d = 1'b0;
      ecall_d  = 1'b0;
      src_d    = SRC_LSU;
    end else begin
      valid_d  = 1'b0;
    end
  end

  // State registers; reset leaves the pointer on LSU so EXU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= SRC_LSU;
      valid_q  <= 1'b0;
      rd_q     <= {RW{1'b0}};
      wd_q     <= {XLEN{1'b0}};
      reg_we_q <= 1'b0;
      csr_rd_q <= {CW{1'b0}};
      csr_wd_q <= {XLEN{1'b0}};
      csr_we_q <= 1'b0;
      ecall_q  <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
      reg_we_q <= reg_we_d;
      csr_rd_q <= csr_rd_d;
      csr_wd_q <= csr_wd_d;
      csr_we_q <= csr_we_d;
      ecall_q  <= ecall_d;
      src_q    <= src_d;
    end
  end

  assign wb_valid  = valid_q;
  assign wb_rd     = rd_q;
  assign wb_wd     = wd_q;
  assign wb_reg_we = reg_we_q;
  assign wb_csr_rd = csr_rd_q;
  assign wb_csr_wd = csr_wd_q;
  assign wb_csr_we = csr_we_q;
  assign wb_ecall  = ecall_q;
  assign wb_src    = src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants and writeback results.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, hold;
  logic            exu_valid, exu_ready, exu_reg_we, exu_csr_we, exu_ecall;
  logic [RW-1:0]   exu_rd;
  logic [XLEN-1:0] exu_wd, exu_csr_wd;
  logic [CW-1:0]   exu_csr_rd;
  logic            lsu_valid, lsu_ready, lsu_reg_we;
  logic [RW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_wd;
  logic            wb_valid, wb_reg_we, wb_csr_we, wb_ecall, wb_src;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_wd, wb_csr_wd;
  logic [CW-1:0]   wb_csr_rd;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.XLEN(XLEN), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wd(exu_wd),
    .exu_reg_we(exu_reg_we), .exu_csr_rd(exu_csr_rd), .exu_csr_wd(exu_csr_wd),
    .exu_csr_we(exu_csr_we), .exu_ecall(exu_ecall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .lsu_reg_we(lsu_reg_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_reg_we(wb_reg_we),
    .wb_csr_rd(wb_csr_rd), .wb_csr_wd(wb_csr_wd), .wb_csr_we(wb_csr_we),
    .wb_ecall(wb_ecall), .wb_src(wb_src)
  );

  // Reference model: who was served last, and the write expected on the port.
  int              m_last;   // 0 = EXU, 1 = LSU
  logic            m_valid, m_reg_we, m_csr_we, m_ecall, m_src;
  logic [RW-1:0]   m_rd;
  logic [XLEN-1:0] m_wd, m_csr_wd;
  logic [CW-1:0]   m_csr_rd;

  function automatic int grant_of();
    if (hold) return -1;
    if (exu_valid && lsu_valid) return (m_last == 1) ? 0 : 1;
    if (exu_valid) return 0;
    if (lsu_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_valid = 1'b0; m_reg_we = 1'b0; m_csr_we = 1'b0; m_ecall = 1'b0; m_src = 1'b0;
    m_rd = '0; m_wd = '0; m_csr_rd = '0; m_csr_wd = '0;
  endtask

  task automatic idle_inputs();
    hold = 1'b0;
    exu_valid = 1'b0; exu_rd = '0; exu_wd = '0; exu_reg_we = 1'b0;
    exu_csr_rd = '0; exu_csr_wd = '0; exu_csr_we = 1'b0; exu_ecall = 1'b0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0; lsu_reg_we = 1'b0;
  endtask

  // One clock: decide the transfer from current inputs, advance the model, settle.
  task automatic tick();
    int g;
    g = grant_of();
    @(posedge clk);
    if (g == 0) begin
      m_last = 0; m_valid = 1'b1; m_src = 1'b0;
      m_rd = exu_rd; m_wd = exu_wd; m_reg_we = exu_reg_we && (exu_rd != 0);
      m_csr_rd = exu_csr_rd; m_csr_wd = exu_csr_wd; m_csr_we = exu_csr_we; m_ecall = exu_ecall;
    end else if (g == 1) begin
      m_last = 1; m_valid = 1'b1; m_src = 1'b1;
      m_rd = lsu_rd; m_wd = lsu_wd; m_reg_we = lsu_reg_we && (lsu_rd != 0);
      m_csr_rd = '0; m_csr_wd = '0; m_csr_we = 1'b0; m_ecall = 1'b0;
    end else begin
      m_valid = 1'b0; m_reg_we = 1'b0; m_csr_we = 1'b0; m_ecall = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    checks++;
    if ({wb_valid, wb_rd, wb_wd, wb_reg_we, wb_csr_rd, wb_csr_wd, wb_csr_we, wb_ecall, wb_src} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b rd=%0d wd=%h we=%b csr_we=%b ecall=%b src=%b, want all zero",
               wb_valid, wb_rd, wb_wd, wb_reg_we, wb_csr_we, wb_ecall, wb_src);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    exu_valid = 1'b1; exu_rd = 5'd1; exu_wd = 32'h1111; exu_reg_we = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'h2222; lsu_reg_we = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({exu_ready, lsu_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got exu_ready=%b lsu_ready=%b", i, exu_ready, lsu_ready);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
        errors++;
        $display("FAIL alt_wb[%0d]: got valid=%b rd=%0d, want valid=1 rd=%0d", i, wb_valid, wb_rd,
                 (i % 2 == 0) ? 1 : 2);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL alt_drain: got wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_single_exu();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_wd = 32'hDEADBEEF; exu_reg_we = 1'b1;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got exu_ready=%b lsu_ready=%b want 1 0", exu_ready, lsu_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_wd !== 32'hDEADBEEF || wb_reg_we !== 1'b1 || wb_src !== 1'b0) begin
      errors++;
      $display("FAIL single_wb: got valid=%b rd=%0d wd=%h we=%b src=%b want 1 5 deadbeef 1 0",
               wb_valid, wb_rd, wb_wd, wb_reg_we, wb_src);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_reg_we !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got valid=%b we=%b want 0 0", wb_valid, wb_reg_we);
    end
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h55; lsu_reg_we = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_reg_we !== 1'b0 || wb_wd !== 32'h55 || wb_src !== 1'b1
        || wb_csr_we !== 1'b0 || wb_ecall !== 1'b0) begin
      errors++;
      $display("FAIL x0_filter: got valid=%b rd=%0d we=%b wd=%h src=%b csr_we=%b ecall=%b",
               wb_valid, wb_rd, wb_reg_we, wb_wd, wb_src, wb_csr_we, wb_ecall);
    end
    tick();
  endtask

  task automatic test_ecall();
    exu_valid = 1'b1; exu_ecall = 1'b1; exu_csr_we = 1'b1; exu_csr_rd = 2'd1; exu_csr_wd = 32'h80000010;
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_ecall !== 1'b1 || wb_csr_we !== 1'b1 || wb_csr_rd !== 2'd1 || wb_csr_wd !== 32'h80000010) begin
      errors++;
      $display("FAIL ecall_wb: got valid=%b ecall=%b csr_we=%b csr_rd=%0d csr_wd=%h",
               wb_valid, wb_ecall, wb_csr_we, wb_csr_rd, wb_csr_wd);
    end
    tick();
    checks++;
    if (wb_ecall !== 1'b0 || wb_csr_we !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL ecall_pulse: got ecall=%b csr_we=%b valid=%b want 0 0 0", wb_ecall, wb_csr_we, wb_valid);
    end
  endtask

  task automatic test_hold();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_reg_we = 1'b1;
    tick();
    hold = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_reg_we = 1'b1;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_inflight: got wb_valid=%b exu_ready=%b lsu_ready=%b want 1 0 0",
               wb_valid, exu_ready, lsu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0 || exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got wb_valid=%b exu_ready=%b lsu_ready=%b want 0 0 0",
                 i, wb_valid, exu_ready, lsu_ready);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (exu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got exu_ready=%b lsu_ready=%b want 0 1", exu_ready, lsu_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL hold_first: got valid=%b src=%b rd=%0d want 1 1 9", wb_valid, wb_src, wb_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    exu_valid = 1'b1; exu_rd = 5'd3; exu_wd = 32'hA5A5; exu_reg_we = 1'b1;
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_reg_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got wb_valid=%b wb_reg_we=%b want 0 0", wb_valid, wb_reg_we);
    end
    #2;
    rst = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_reg_we = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_reg_we = 1'b1;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie: got exu_ready=%b lsu_ready=%b want 1 0", exu_ready, lsu_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_rd !== 5'd4) begin
      errors++;
      $display("FAIL rst_first: got valid=%b src=%b rd=%0d want 1 0 4", wb_valid, wb_src, wb_rd);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    int exu_wait, lsu_wait;
    g = -1; exu_wait = 0; lsu_wait = 0;
    for (int i = 0; i < 400; i++) begin
      if (!exu_valid || g == 0) begin
        exu_valid = ($urandom_range(0, 2) != 0);
        exu_rd = 5'($urandom_range(0, 31)); exu_wd = $urandom(); exu_reg_we = 1'($urandom_range(0, 1));
        exu_csr_rd = 2'($urandom_range(0, 3)); exu_csr_wd = $urandom();
        exu_csr_we = 1'($urandom_range(0, 1)); exu_ecall = 1'($urandom_range(0, 1));
      end
      if (!lsu_valid || g == 1) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd = 5'($urandom_range(0, 31)); lsu_wd = $urandom(); lsu_reg_we = 1'($urandom_range(0, 1));
      end
      hold = ($urandom_range(0, 7) == 0);
      #1;
      g = grant_of();
      checks++;
      if (exu_ready !== (g == 0) || lsu_ready !== (g == 1)) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got exu=%b lsu=%b want grant %0d", i, exu_ready, lsu_ready, g);
      end
      if (!hold && exu_valid && g != 0) exu_wait++; else exu_wait = 0;
      if (!hold && lsu_valid && g != 1) lsu_wait++; else lsu_wait = 0;
      checks++;
      if (exu_wait > 1 || lsu_wait > 1) begin
        errors++;
        $display("FAIL rnd_fair[%0d]: exu_wait=%0d lsu_wait=%0d want <=1", i, exu_wait, lsu_wait);
      end
      tick();
      checks++;
      if (wb_valid !== m_valid || wb_reg_we !== m_reg_we || wb_csr_we !== m_csr_we || wb_ecall !== m_ecall) begin
        errors++;
        $display("FAIL rnd_ctl[%0d]: got v=%b we=%b cwe=%b ec=%b want %b %b %b %b", i,
                 wb_valid, wb_reg_we, wb_csr_we, wb_ecall, m_valid, m_reg_we, m_csr_we, m_ecall);
      end
      if (m_valid) begin
        checks++;
        if (wb_src !== m_src || wb_rd !== m_rd || wb_wd !== m_wd || wb_csr_rd !== m_csr_rd || wb_csr_wd !== m_csr_wd) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got src=%b rd=%0d wd=%h crd=%0d cwd=%h want %b %0d %h %0d %h", i,
                   wb_src, wb_rd, wb_wd, wb_csr_rd, wb_csr_wd, m_src, m_rd, m_wd, m_csr_rd, m_csr_wd);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_exu();
    test_x0();
    test_ecall();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
